hbconsole_mux: RTL

Multi-channel console/hexbus byte multiplexer for the debug UART link. Merges one hexbus transmit stream and `NCONSOLE` 7-bit console transmit streams onto a single serial-transmit byte port. Splits the receive byte stream back into hexbus bytes and per-channel console bytes. Sits between the hexbus encode/decode chain and the UART, replacing the single-console arbiter with buffered, channel-tagged console traffic.

---
 rtl/hbconsole_mux_if.sv | 35 +++
 rtl/hbconsole_mux.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hbconsole_mux_if.sv
// Byte-level port bundle of hbconsole_mux: hexbus/console transmit inputs,
// UART transmit/receive bytes and the split receive outputs.
interface hbconsole_mux_if #(
  parameter int NCONSOLE = 2
);
  logic                     i_hb_stb;
  logic [6:0]               i_hb_byte;
  logic                     o_hb_busy;
  logic [NCONSOLE-1:0]      i_console_stb;
  logic [7*NCONSOLE-1:0]    i_console_data;
  logic [NCONSOLE-1:0]      o_console_busy;
  logic                     o_tx_stb;
  logic [7:0]               o_tx_data;
  logic                     i_tx_busy;
  logic                     i_rx_stb;
  logic [7:0]               i_rx_byte;
  logic                     o_hb_rx_stb;
  logic [7:0]               o_hb_rx_byte;
  logic [NCONSOLE-1:0]      o_console_stb;
  logic [6:0]               o_console_data;

  modport master (
    output i_hb_stb, i_hb_byte, i_console_stb, i_console_data, i_tx_busy,
           i_rx_stb, i_rx_byte,
    input  o_hb_busy, o_console_busy, o_tx_stb, o_tx_data, o_hb_rx_stb,
           o_hb_rx_byte, o_console_stb, o_console_data
  );

  modport slave (
    input  i_hb_stb, i_hb_byte, i_console_stb, i_console_data, i_tx_busy,
           i_rx_stb, i_rx_byte,
    output o_hb_busy, o_console_busy, o_tx_stb, o_tx_data, o_hb_rx_stb,
           o_hb_rx_byte, o_console_stb, o_console_data
  );
endinterface

// File: rtl/hbconsole_mux.sv
// Hexbus + multi-channel console byte multiplexer for the debug UART link.
// Define HBCONSOLE_MUX_ROUNDROBIN_EN for round-robin console grant (default: fixed priority).
module hbconsole_mux #(
  parameter int NCONSOLE = 2,
  parameter int LGFIFO   = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  hbconsole_mux_if.slave  bus
);
  localparam int DEPTH = 1 << LGFIFO;
  localparam int PW    = LGFIFO + 1;

  typedef enum logic {S_DATA, S_SEL} state_t;

  state_t              state_q;
  logic                tx_stb_q;
  logic [7:0]          tx_data_q;
  logic [3:0]          tx_chan_q;

  logic [NCONSOLE-1:0] fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic [6:0]          fifo_rdata [NCONSOLE];
  logic                loadable, pop_en, any_ne;
  logic [3:0]          grant;
  logic [6:0]          grant_data;

  // FIFO read is combinational so a pop can load the output register the same cycle.
  for (genvar gi = 0; gi < NCONSOLE; gi++) begin : g_fifo
    logic [6:0]    mem [DEPTH];
    logic [PW-1:0] wr_q, rd_q;

    assign fifo_empty[gi] = (wr_q == rd_q);
    assign fifo_full[gi]  = ((wr_q - rd_q) == PW'(DEPTH));
    assign fifo_push[gi]  = bus.i_console_stb[gi] && !fifo_full[gi];
    assign fifo_pop[gi]   = pop_en && (grant == 4'(gi));
    assign fifo_rdata[gi] = mem[rd_q[LGFIFO-1:0]];

    always_ff @(posedge i_clk) begin
      if (fifo_push[gi])
        mem[wr_q[LGFIFO-1:0]] <= bus.i_console_data[7*gi +: 7];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (fifo_push[gi]) wr_q <= wr_q + PW'(1);
        if (fifo_pop[gi])  rd_q <= rd_q + PW'(1);
      end
    end
  end

  assign bus.o_console_busy = fifo_full;
  assign any_ne             = !(&fifo_empty);

`ifdef HBCONSOLE_MUX_ROUNDROBIN_EN
  logic [3:0]    ptr_q, owner_q, grant_hi, grant_lo;
  logic          lock_q, owner_ne, hi_found;
  logic [PW-1:0] burst_q, burst_d;

  // The owner keeps the grant while nonempty; otherwise first nonempty at or after ptr_q.
  always_comb begin
    grant_hi = '0;
    grant_lo = '0;
    hi_found = 1'b0;
    owner_ne = 1'b0;
    for (int k = NCONSOLE - 1; k >= 0; k--) begin
      if (owner_q == 4'(k)) owner_ne = !fifo_empty[k];
      if (!fifo_empty[k]) begin
        grant_lo = 4'(k);
        if (4'(k) >= ptr_q) begin
          grant_hi = 4'(k);
          hi_found = 1'b1;
        end
      end
    end
    if (lock_q && owner_ne) grant = owner_q;
    else if (hi_found)      grant = grant_hi;
    else                    grant = grant_lo;
  end

  assign burst_d = (lock_q && owner_q == grant) ? burst_q + PW'(1) : PW'(1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ptr_q   <= '0;
      owner_q <= '0;
      lock_q  <= 1'b0;
      burst_q <= '0;
    end else if (pop_en) begin
      ptr_q   <= (grant == 4'(NCONSOLE - 1)) ? 4'd0 : grant + 4'd1;
      owner_q <= grant;
      lock_q  <= (burst_d != PW'(DEPTH));
      burst_q <= burst_d;
    end
  end
`else
  always_comb begin
    grant = '0;
    for (int k = NCONSOLE - 1; k >= 0; k--)
      if (!fifo_empty[k]) grant = 4'(k);
  end
`endif

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < NCONSOLE; k++)
      if (grant == 4'(k)) grant_data = fifo_rdata[k];
  end

  assign loadable      = !tx_stb_q || !bus.i_tx_busy;
  assign pop_en        = (state_q == S_DATA) && loadable && !bus.i_hb_stb && any_ne
                         && (grant == tx_chan_q);
  assign bus.o_hb_busy = !((state_q == S_DATA) && loadable);
  assign bus.o_tx_stb  = tx_stb_q;
  assign bus.o_tx_data = tx_data_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_DATA;
      tx_stb_q  <= 1'b0;
      tx_data_q <= '0;
      tx_chan_q <= '0;
    end else if (loadable) begin
      case (state_q)
        S_DATA: begin
          if (bus.i_hb_stb) begin
            tx_stb_q  <= 1'b1;
            tx_data_q <= {1'b1, bus.i_hb_byte};
          end else if (any_ne) begin
            tx_stb_q <= 1'b1;
            if (grant == tx_chan_q) begin
              tx_data_q <= {1'b0, grant_data};
            end else begin
              tx_data_q <= 8'hFF;
              state_q   <= S_SEL;
            end
          end else begin
            tx_stb_q <= 1'b0;
          end
        end
        S_SEL: begin
          tx_stb_q  <= 1'b1;
          tx_data_q <= {4'h0, grant};
          tx_chan_q <= grant;
          state_q   <= S_DATA;
        end
        default: state_q <= S_DATA;
      endcase
    end
  end

  logic [3:0]          rx_chan_q;
  logic                rx_sel_q, hb_rx_stb_q;
  logic [7:0]          hb_rx_byte_q;
  logic [NCONSOLE-1:0] con_stb_q, rx_onehot;
  logic [6:0]          con_data_q;

  always_comb begin
    rx_onehot = '0;
    for (int k = 0; k < NCONSOLE; k++)
      rx_onehot[k] = (rx_chan_q == 4'(k));
  end

  // A byte following 8'hFF is always consumed as a channel select, even when out of range.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_chan_q    <= '0;
      rx_sel_q     <= 1'b0;
      hb_rx_stb_q  <= 1'b0;
      hb_rx_byte_q <= '0;
      con_stb_q    <= '0;
      con_data_q   <= '0;
    end else begin
      hb_rx_stb_q <= 1'b0;
      con_stb_q   <= '0;
      if (bus.i_rx_stb) begin
        if (rx_sel_q) begin
          rx_sel_q <= 1'b0;
          if (int'(bus.i_rx_byte[3:0]) < NCONSOLE) rx_chan_q <= bus.i_rx_byte[3:0];
        end else if (bus.i_rx_byte == 8'hFF) begin
          rx_sel_q <= 1'b1;
        end else if (bus.i_rx_byte[7]) begin
          hb_rx_stb_q  <= 1'b1;
          hb_rx_byte_q <= bus.i_rx_byte;
        end else begin
          con_stb_q  <= rx_onehot;
          con_data_q <= bus.i_rx_byte[6:0];
        end
      end
    end
  end

  assign bus.o_hb_rx_stb    = hb_rx_stb_q;
  assign bus.o_hb_rx_byte   = hb_rx_byte_q;
  assign bus.o_console_stb  = con_stb_q;
  assign bus.o_console_data = con_data_q;
endmodule
